// File: rtl/axi_r_resp_arbiter_if.sv
`timescale 1ns/1ps
// Signal bundle of axi_r_resp_arbiter: merged R channels, outstanding counter
// status and the decode-error queue. "slave" is the arbiter side, "master" the environment.
interface axi_r_resp_arbiter_if #(
   parameter int N_INIT_PORT = 4,
   parameter int AXI_DATA_W  = 64,
   parameter int AXI_USER_W  = 6,
   parameter int AXI_ID_IN   = 16,
   parameter int AXI_ID_OUT  = AXI_ID_IN + 2
);
   // Per-port R payload from the master-side ports
   logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0] rid_i;
   logic [N_INIT_PORT-1:0][AXI_DATA_W-1:0] rdata_i;
   logic [N_INIT_PORT-1:0][1:0]            rresp_i;
   logic [N_INIT_PORT-1:0]                 rlast_i;
   logic [N_INIT_PORT-1:0][AXI_USER_W-1:0] ruser_i;
   logic [N_INIT_PORT-1:0]                 rvalid_i;
   logic [N_INIT_PORT-1:0]                 rready_o;

   // Merged R channel toward the slave port
   logic [AXI_ID_IN-1:0]  rid_o;
   logic [AXI_DATA_W-1:0] rdata_o;
   logic [1:0]            rresp_o;
   logic                  rlast_o;
   logic [AXI_USER_W-1:0] ruser_o;
   logic                  rvalid_o;
   logic                  rready_i;

   // Outstanding-transaction tracking
   logic                  incr_req_i;
   logic                  full_counter_o;
   logic                  outstanding_trans_o;

   // Decode-error queue
   logic                  err_req_i;
   logic                  err_gnt_o;
   logic [7:0]            err_len_i;
   logic [AXI_ID_IN-1:0]  err_id_i;
   logic [AXI_USER_W-1:0] err_user_i;
   logic                  err_pending_o;

   modport slave (
      input  rid_i, rdata_i, rresp_i, rlast_i, ruser_i, rvalid_i,
      output rready_o,
      output rid_o, rdata_o, rresp_o, rlast_o, ruser_o, rvalid_o,
      input  rready_i,
      input  incr_req_i,
      output full_counter_o, outstanding_trans_o,
      input  err_req_i, err_len_i, err_id_i, err_user_i,
      output err_gnt_o, err_pending_o
   );

   modport master (
      output rid_i, rdata_i, rresp_i, rlast_i, ruser_i, rvalid_i,
      input  rready_o,
      input  rid_o, rdata_o, rresp_o, rlast_o, ruser_o, rvalid_o,
      output rready_i,
      output incr_req_i,
      input  full_counter_o, outstanding_trans_o,
      output err_req_i, err_len_i, err_id_i, err_user_i,
      input  err_gnt_o, err_pending_o
   );
endinterface

// File: rtl/axi_r_resp_arbiter.sv
`timescale 1ns/1ps
// Burst-locked round-robin merge of N read-response channels onto one slave R
// channel, plus synthesised responses for queued decode-error bursts.
module axi_r_resp_arbiter #(
   parameter int         N_INIT_PORT = 4,
   parameter int         AXI_DATA_W  = 64,
   parameter int         AXI_USER_W  = 6,
   parameter int         AXI_ID_IN   = 16,
   parameter int         AXI_ID_OUT  = AXI_ID_IN + 2,
   parameter int         OUTST_W     = 10,
   parameter int         ERR_DEPTH   = 4,
   parameter logic [1:0] ERR_RESP    = 2'b11
) (
   input logic                 clk,
   input logic                 rst,
   axi_r_resp_arbiter_if.slave bus
);

   localparam int PORT_W = $clog2(N_INIT_PORT);
   localparam int ERR_AW = $clog2(ERR_DEPTH);
   localparam logic [AXI_DATA_W-1:0] ERR_DATA = {(AXI_DATA_W/32){32'hDEADBEEF}};

   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_LOCK = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0]            len;
      logic [AXI_ID_IN-1:0]  id;
      logic [AXI_USER_W-1:0] user;
   } err_entry_t;

   state_t                state;
   logic [PORT_W-1:0]     rr_ptr;
   logic [PORT_W-1:0]     lock_idx;
   logic [OUTST_W-1:0]    cnt;
   logic [7:0]            beat_cnt;
   logic                  err_pending;

   logic [ERR_AW:0]       wr_ptr, rd_ptr;
   logic [ERR_AW:0]       wr_ptr_nxt, rd_ptr_nxt;
   err_entry_t            err_mem [ERR_DEPTH];
   err_entry_t            err_head;
   logic                  err_empty, err_full;
   logic                  err_push, err_pop, err_last;

   logic                  gnt_found;
   logic [PORT_W-1:0]     gnt_idx;
   logic [PORT_W-1:0]     sel_idx;
   logic                  enter_err;
   logic                  port_path;
   logic                  port_hs, port_last_hs;

   logic [AXI_ID_IN-1:0]   out_rid;
   logic [AXI_DATA_W-1:0]  out_rdata;
   logic [1:0]             out_rresp;
   logic                   out_rlast;
   logic [AXI_USER_W-1:0]  out_ruser;
   logic                   out_rvalid;
   logic [N_INIT_PORT-1:0] out_rready;

   // Upper ID bits carry the interconnect's port tag and are dropped here.
   logic id_hi_unused;
   assign id_hi_unused = ^bus.rid_i;

   // ------------------------------------------------------------------
   // Round-robin search: first valid port after rr_ptr, wrapping.
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 1; k <= N_INIT_PORT; k++) begin
         int                cand;
         logic [PORT_W-1:0] cidx;
         cand = int'(rr_ptr) + k;
         if (cand >= N_INIT_PORT) cand = cand - N_INIT_PORT;
         cidx = PORT_W'(cand);
         if (!gnt_found && bus.rvalid_i[cidx]) begin
            gnt_found = 1'b1;
            gnt_idx   = cidx;
         end
      end
   end

   assign enter_err = (state == ST_ARB) && !err_empty && (cnt == '0);

   always_comb begin
      port_path = 1'b0;
      sel_idx   = gnt_idx;
      case (state)
         ST_ARB:  port_path = gnt_found && !enter_err;
         ST_LOCK: begin
            port_path = 1'b1;
            sel_idx   = lock_idx;
         end
         default: port_path = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Output mux: granted/locked port, synthesised error beat, or idle.
   // ------------------------------------------------------------------
   always_comb begin
      out_rid    = '0;
      out_rdata  = '0;
      out_rresp  = '0;
      out_rlast  = 1'b0;
      out_ruser  = '0;
      out_rvalid = 1'b0;
      out_rready = '0;
      if (!rst) begin
         if (port_path) begin
            out_rid             = bus.rid_i[sel_idx][AXI_ID_IN-1:0];
            out_rdata           = bus.rdata_i[sel_idx];
            out_rresp           = bus.rresp_i[sel_idx];
            out_rlast           = bus.rlast_i[sel_idx];
            out_ruser           = bus.ruser_i[sel_idx];
            out_rvalid          = bus.rvalid_i[sel_idx];
            out_rready[sel_idx] = bus.rready_i;
         end else if (state == ST_ERR) begin
            out_rid    = err_head.id;
            out_rdata  = ERR_DATA;
            out_rresp  = ERR_RESP;
            out_rlast  = err_last;
            out_ruser  = err_head.user;
            out_rvalid = 1'b1;
         end
      end
   end

   assign port_hs      = port_path && out_rvalid && bus.rready_i;
   assign port_last_hs = port_hs && out_rlast;

   // ------------------------------------------------------------------
   // Error queue bookkeeping
   // ------------------------------------------------------------------
   assign err_empty  = (wr_ptr == rd_ptr);
   assign err_full   = (wr_ptr[ERR_AW] != rd_ptr[ERR_AW]) &&
                       (wr_ptr[ERR_AW-1:0] == rd_ptr[ERR_AW-1:0]);
   assign err_head   = err_mem[rd_ptr[ERR_AW-1:0]];
   assign err_last   = (beat_cnt == err_head.len);
   assign err_push   = bus.err_req_i && !err_full;
   assign err_pop    = (state == ST_ERR) && bus.rready_i && err_last;
   assign wr_ptr_nxt = wr_ptr + (ERR_AW+1)'(err_push);
   assign rd_ptr_nxt = rd_ptr + (ERR_AW+1)'(err_pop);

   // NOTE: the queue storage has no reset; the pointers alone say which entries are live.
   always_ff @(posedge clk) begin
      if (err_push) begin
         err_mem[wr_ptr[ERR_AW-1:0]] <= '{len: bus.err_len_i, id: bus.err_id_i, user: bus.err_user_i};
      end
   end

   // ------------------------------------------------------------------
   // FSM, round-robin pointer, outstanding counter and queue pointers
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_ARB;
         rr_ptr      <= PORT_W'(N_INIT_PORT - 1);
         lock_idx    <= '0;
         cnt         <= '0;
         beat_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         err_pending <= 1'b0;
      end else begin
         case (state)
            ST_ARB: begin
               if (enter_err) begin
                  state <= ST_ERR;
               end else if (port_hs) begin
                  rr_ptr <= gnt_idx;
                  if (!out_rlast) begin
                     lock_idx <= gnt_idx;
                     state    <= ST_LOCK;
                  end
               end
            end
            ST_LOCK: begin
               if (port_last_hs) state <= ST_ARB;
            end
            ST_ERR: begin
               if (bus.rready_i) begin
                  if (err_last) begin
                     beat_cnt <= '0;
                     state    <= ST_ARB;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            default: state <= ST_ARB;
         endcase

         // Error beats never touch the counter; simultaneous incr/decr cancel.
         if (bus.incr_req_i && !port_last_hs) begin
            if (cnt != '1) cnt <= cnt + OUTST_W'(1);
         end else if (!bus.incr_req_i && port_last_hs) begin
            if (cnt != '0) cnt <= cnt - OUTST_W'(1);
         end

         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         err_pending <= (wr_ptr_nxt != rd_ptr_nxt);
      end
   end

   assign bus.rid_o               = out_rid;
   assign bus.rdata_o             = out_rdata;
   assign bus.rresp_o             = out_rresp;
   assign bus.rlast_o             = out_rlast;
   assign bus.ruser_o             = out_ruser;
   assign bus.rvalid_o            = out_rvalid;
   assign bus.rready_o            = out_rready;
   assign bus.full_counter_o      = (cnt == '1);
   assign bus.outstanding_trans_o = (cnt != '0);
   assign bus.err_gnt_o           = !err_full;
   assign bus.err_pending_o       = err_pending;

endmodule

// File: tb/tb_axi_r_resp_arbiter.sv
`timescale 1ns/1ps
// Directed self-checking bench for axi_r_resp_arbiter: round-robin, burst lock,
// error synthesis, queue full, counter saturation and reset mid-burst.
module tb_axi_r_resp_arbiter;
   localparam int N   = 4;
   localparam int DW  = 64;
   localparam int UW  = 6;
   localparam int IDI = 16;
   localparam int IDO = 18;
   localparam logic [DW-1:0] DEAD = 64'hDEADBEEF_DEADBEEF;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   axi_r_resp_arbiter_if #(.N_INIT_PORT(N), .AXI_DATA_W(DW), .AXI_USER_W(UW),
                           .AXI_ID_IN(IDI), .AXI_ID_OUT(IDO)) bus ();

   axi_r_resp_arbiter #(
      .N_INIT_PORT(N), .AXI_DATA_W(DW), .AXI_USER_W(UW), .AXI_ID_IN(IDI),
      .AXI_ID_OUT(IDO), .OUTST_W(10), .ERR_DEPTH(4), .ERR_RESP(2'b11)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_port(input int p, input logic v, input logic last,
                           input logic [IDO-1:0] id, input logic [DW-1:0] data,
                           input logic [1:0] resp);
      bus.rvalid_i[p] = v;
      bus.rlast_i[p]  = last;
      bus.rid_i[p]    = id;
      bus.rdata_i[p]  = data;
      bus.rresp_i[p]  = resp;
      bus.ruser_i[p]  = UW'(p + 1);
   endtask

   task automatic idle_ports();
      bus.rvalid_i = '0;
   endtask

   // Waits (bounded) for the next synthesised error beat.
   task automatic wait_err(input string tag);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         tick();
         settle();
         seen = bus.rvalid_o && (bus.rresp_o == 2'b11);
      end
      check({tag, "_reached"}, 64'(seen), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus.rready_i   = 1'b1;
      bus.incr_req_i = 1'b0;
      bus.err_req_i  = 1'b0;
      bus.err_len_i  = '0;
      bus.err_id_i   = '0;
      bus.err_user_i = '0;
      for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b1, IDO'(18'h3_0F00 + p), 64'hFACE_0000 + 64'(p), 2'b10);

      // Reset state while every port presents a valid beat
      #3;
      check("rst_rvalid", bus.rvalid_o, 0);
      check("rst_rready", bus.rready_o, 0);
      check("rst_rdata", bus.rdata_o, 0);
      check("rst_rid", bus.rid_o, 0);
      check("rst_full", bus.full_counter_o, 0);
      check("rst_outst", bus.outstanding_trans_o, 0);
      check("rst_pend", bus.err_pending_o, 0);
      check("rst_gnt", bus.err_gnt_o, 1);
      @(posedge clk);
      @(negedge clk);
      idle_ports();
      rst = 1'b0;

      // Single-beat round robin between ports 0 and 2
      tick();
      set_port(0, 1'b1, 1'b1, 18'h3_1234, 64'hA0, 2'b00);
      set_port(2, 1'b1, 1'b1, 18'h2_ABCD, 64'hA2, 2'b00);
      for (int i = 0; i < 4; i++) begin
         settle();
         check($sformatf("rr_gnt%0d", i), bus.rready_o, (i % 2 == 0) ? 64'h1 : 64'h4);
         check($sformatf("rr_rid%0d", i), bus.rid_o, (i % 2 == 0) ? 64'h1234 : 64'hABCD);
         tick();
      end
      idle_ports();
      settle();
      check("decr_at_zero", bus.outstanding_trans_o, 0);

      // Burst lock: port 1 four beats (with a bubble), port 3 waiting
      tick();
      set_port(1, 1'b1, 1'b0, 18'h0_0011, 64'hD0, 2'b00);
      settle();
      check("lock_b0_gnt", bus.rready_o, 4'b0010);
      check("lock_b0_data", bus.rdata_o, 64'hD0);
      tick();
      set_port(1, 1'b1, 1'b0, 18'h0_0011, 64'hD1, 2'b00);
      set_port(3, 1'b1, 1'b1, 18'h1_3333, 64'hE3, 2'b00);
      settle();
      check("lock_b1_gnt", bus.rready_o, 4'b0010);
      check("lock_b1_data", bus.rdata_o, 64'hD1);
      tick();
      bus.rvalid_i[1] = 1'b0;
      settle();
      check("lock_bubble_valid", bus.rvalid_o, 0);
      check("lock_bubble_p3", bus.rready_o[3], 0);
      tick();
      set_port(1, 1'b1, 1'b0, 18'h0_0011, 64'hD2, 2'b00);
      settle();
      check("lock_b2_gnt", bus.rready_o, 4'b0010);
      tick();
      set_port(1, 1'b1, 1'b1, 18'h0_0011, 64'hD3, 2'b00);
      settle();
      check("lock_b3_gnt", bus.rready_o, 4'b0010);
      check("lock_b3_last", bus.rlast_o, 1);
      tick();
      bus.rvalid_i[1] = 1'b0;
      settle();
      check("lock_release_p3", bus.rready_o, 4'b1000);
      check("lock_release_rid", bus.rid_o, 64'h3333);
      tick();
      idle_ports();

      // Error burst served only after two outstanding reads drain
      tick();
      bus.incr_req_i = 1'b1;
      tick();
      tick();
      bus.incr_req_i = 1'b0;
      bus.err_req_i  = 1'b1;
      bus.err_len_i  = 8'd3;
      bus.err_id_i   = 16'h005A;
      bus.err_user_i = 6'h15;
      settle();
      check("err_push_gnt", bus.err_gnt_o, 1);
      check("err_pend_before", bus.err_pending_o, 0);
      tick();
      bus.err_req_i = 1'b0;
      settle();
      check("err_pend_after", bus.err_pending_o, 1);
      check("err_outst", bus.outstanding_trans_o, 1);
      check("err_wait_valid", bus.rvalid_o, 0);
      tick();
      set_port(0, 1'b1, 1'b1, 18'h0_0001, 64'hB0, 2'b01);
      settle();
      check("drain1_gnt", bus.rready_o, 4'b0001);
      check("drain1_resp", bus.rresp_o, 2'b01);
      tick();
      bus.rvalid_i[0] = 1'b0;
      set_port(2, 1'b1, 1'b1, 18'h0_0002, 64'hB2, 2'b00);
      bus.incr_req_i = 1'b1;
      settle();
      check("incr_decr_gnt", bus.rready_o, 4'b0100);
      tick();
      idle_ports();
      bus.incr_req_i = 1'b0;
      settle();
      check("no_err_yet0", bus.rvalid_o, 0);
      tick();
      settle();
      check("no_err_yet1", bus.rvalid_o, 0);
      check("incr_decr_outst", bus.outstanding_trans_o, 1);
      tick();
      set_port(1, 1'b1, 1'b1, 18'h0_0003, 64'hB1, 2'b00);
      settle();
      check("drain2_gnt", bus.rready_o, 4'b0010);
      tick();
      bus.rvalid_i[1] = 1'b0;
      set_port(3, 1'b1, 1'b1, 18'h1_3333, 64'hB3, 2'b00);
      settle();
      check("err_decide_valid", bus.rvalid_o, 0);
      check("err_decide_rready", bus.rready_o, 0);
      check("err_decide_outst", bus.outstanding_trans_o, 0);
      for (int b = 0; b < 4; b++) begin
         tick();
         if (b == 1) begin
            bus.rready_i = 1'b0;
            settle();
            check("err_stall_last", bus.rlast_o, 0);
            tick();
            bus.rready_i = 1'b1;
         end
         settle();
         check($sformatf("err_b%0d_valid", b), bus.rvalid_o, 1);
         check($sformatf("err_b%0d_data", b), bus.rdata_o, DEAD);
         check($sformatf("err_b%0d_resp", b), bus.rresp_o, 2'b11);
         check($sformatf("err_b%0d_rid", b), bus.rid_o, 64'h5A);
         check($sformatf("err_b%0d_user", b), bus.ruser_o, 64'h15);
         check($sformatf("err_b%0d_rready", b), bus.rready_o, 0);
         check($sformatf("err_b%0d_last", b), bus.rlast_o, (b == 3) ? 64'd1 : 64'd0);
      end
      tick();
      settle();
      check("err_done_p3", bus.rready_o, 4'b1000);
      check("err_done_pend", bus.err_pending_o, 0);
      tick();
      idle_ports();

      // Queue full, then push together with a pop
      tick();
      bus.incr_req_i = 1'b1;
      tick();
      bus.incr_req_i = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         bus.err_req_i = 1'b1;
         bus.err_len_i = 8'd0;
         bus.err_id_i  = IDI'(i);
         settle();
         check($sformatf("q_push%0d_gnt", i), bus.err_gnt_o, (i < 5) ? 64'd1 : 64'd0);
      end
      tick();
      bus.err_req_i = 1'b0;
      settle();
      check("q_full_pend", bus.err_pending_o, 1);
      check("q_full_gnt", bus.err_gnt_o, 0);
      tick();
      set_port(0, 1'b1, 1'b1, 18'h0_0004, 64'hC0, 2'b00);
      settle();
      check("q_drain_gnt", bus.rready_o, 4'b0001);
      tick();
      idle_ports();
      settle();
      check("q_decide_valid", bus.rvalid_o, 0);
      wait_err("q1");
      check("q1_rid", bus.rid_o, 64'd1);
      check("q1_last", bus.rlast_o, 1);
      check("q1_full_gnt", bus.err_gnt_o, 0);
      bus.err_req_i = 1'b1;
      bus.err_id_i  = 16'd7;
      tick();
      bus.err_req_i = 1'b0;
      wait_err("q2");
      check("q2_rid", bus.rid_o, 64'd2);
      bus.err_req_i = 1'b1;
      bus.err_id_i  = 16'd6;
      settle();
      check("q_push_with_pop_gnt", bus.err_gnt_o, 1);
      tick();
      bus.err_req_i = 1'b0;
      wait_err("q3");
      check("q3_rid", bus.rid_o, 64'd3);
      wait_err("q4");
      check("q4_rid", bus.rid_o, 64'd4);
      wait_err("q6");
      check("q6_rid", bus.rid_o, 64'd6);
      tick();
      settle();
      check("q_empty_pend", bus.err_pending_o, 0);

      // Counter saturation at 1023
      tick();
      bus.incr_req_i = 1'b1;
      repeat (1022) tick();
      settle();
      check("cnt_1022_full", bus.full_counter_o, 0);
      tick();
      settle();
      check("cnt_1023_full", bus.full_counter_o, 1);
      tick();
      bus.incr_req_i = 1'b0;
      settle();
      check("cnt_sat_full", bus.full_counter_o, 1);
      check("cnt_sat_outst", bus.outstanding_trans_o, 1);
      tick();
      set_port(0, 1'b1, 1'b1, 18'h0_0005, 64'hC1, 2'b00);
      tick();
      idle_ports();
      settle();
      check("cnt_1022_again", bus.full_counter_o, 0);
      check("cnt_1022_outst", bus.outstanding_trans_o, 1);
      tick();
      bus.incr_req_i = 1'b1;
      tick();
      bus.incr_req_i = 1'b0;
      settle();
      check("cnt_refill_full", bus.full_counter_o, 1);

      // Reset during beat 2 of a locked burst on port 2
      tick();
      set_port(2, 1'b1, 1'b0, 18'h0_2222, 64'hC2, 2'b00);
      settle();
      check("rstb_b1_gnt", bus.rready_o, 4'b0100);
      tick();
      set_port(0, 1'b1, 1'b1, 18'h0_0A0A, 64'hF0, 2'b00);
      set_port(1, 1'b1, 1'b1, 18'h0_0B0B, 64'hF1, 2'b00);
      set_port(3, 1'b1, 1'b1, 18'h0_0D0D, 64'hF3, 2'b00);
      set_port(2, 1'b1, 1'b0, 18'h0_2222, 64'hC3, 2'b00);
      settle();
      check("rstb_b2_gnt", bus.rready_o, 4'b0100);
      rst = 1'b1;
      settle();
      check("rstb_valid", bus.rvalid_o, 0);
      check("rstb_rready", bus.rready_o, 0);
      check("rstb_rdata", bus.rdata_o, 0);
      check("rstb_outst", bus.outstanding_trans_o, 0);
      check("rstb_full", bus.full_counter_o, 0);
      @(negedge clk);
      rst = 1'b0;
      set_port(2, 1'b1, 1'b1, 18'h0_2222, 64'hC3, 2'b00);
      settle();
      check("rstb_restart_gnt", bus.rready_o, 4'b0001);
      check("rstb_restart_rid", bus.rid_o, 64'h0A0A);
      check("rstb_restart_valid", bus.rvalid_o, 1);
      tick();
      idle_ports();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_r_resp_arbiter.md
# axi_r_resp_arbiter

Read-response allocator for one AXI slave port of the interconnect. It merges the R channels of N_INIT_PORT master-side ports onto one slave-side R channel. Arbitration is round-robin and burst-locked, so a burst is never interleaved with another port's beats once started. It also queues up to ERR_DEPTH decode-error read bursts and synthesises their responses after all earlier outstanding transactions have drained.

## Interface
Parameters:
- N_INIT_PORT, 4, number of merged R channels (≥2)
- AXI_DATA_W, 64, data width (multiple of 32)
- AXI_USER_W, 6, user width
- AXI_ID_IN, 16, ID width on the output side
- AXI_ID_OUT, AXI_ID_IN+2, ID width on the inputs; the upper bits are discarded
- OUTST_W, 10, width of the outstanding-transaction counter
- ERR_DEPTH, 4, depth of the error queue (power of 2, ≥2)
- ERR_RESP, 2'b11, rresp value driven on synthesised beats

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rid_i/rdata_i/rresp_i/rlast_i/ruser_i  in  N_INIT_PORT×(AXI_ID_OUT/AXI_DATA_W/2/1/AXI_USER_W)  per-port R payload
- rvalid_i  in  N_INIT_PORT  per-port valid
- rready_o  out  N_INIT_PORT  per-port ready
- rid_o/rdata_o/rresp_o/rlast_o/ruser_o  out  AXI_ID_IN/AXI_DATA_W/2/1/AXI_USER_W  merged payload
- rvalid_o  out  1  merged valid
- rready_i  in  1  merged ready
- incr_req_i  in  1  one AR accepted toward the master ports
- full_counter_o  out  1  outstanding counter saturated
- outstanding_trans_o  out  1  counter non-zero
- err_req_i  in  1  push a decode-error burst
- err_gnt_o  out  1  push accepted
- err_len_i  in  8  burst length minus one
- err_id_i  in  AXI_ID_IN  error ID
- err_user_i  in  AXI_USER_W  error user
- err_pending_o  out  1  error queue not empty

## Operation
- FSM states:
  - ARB: no lock held.
  - LOCK: a burst from a port is in progress.
  - ERR: serving the head of the error queue.
- ARB:
  - If the queue is non-empty and the counter is 0, move to ERR and grant nothing.
  - Otherwise, grant the first port with rvalid_i set, searching from rr_ptr+1 upward and wrapping.
  - The grant is combinational. Output payload = granted port; rvalid_o=1; rready_o[g]=rready_i; all other rready_o are 0.
  - On a handshake with rlast=0: store g, go to LOCK.
  - On a handshake with rlast=1: stay in ARB.
  - On either handshake, set rr_ptr←g.
- LOCK:
  - Only the stored port is muxed through; other ports are held at rready_o=0.
  - Return to ARB on the rlast handshake. Lock is held even when the locked port drops rvalid.
- ERR:
  - rvalid_o=1, rresp_o=ERR_RESP.
  - rdata_o = 32'hDEADBEEF replicated across the data width.
  - rid_o and ruser_o come from the queue head.
  - rready_o=0 on every port.
  - The beat counter increments on each handshake. rlast_o=1 when the beat counter equals the head's stored len.
  - On the last handshake: pop the head, clear the beat counter, go to ARB.
- Error queue:
  - FIFO of {len, id, user}.
  - err_gnt_o = !full (combinational). A push happens when err_req_i & err_gnt_o.
  - Push and pop in the same cycle are both allowed. When full, only the pop occurs.
- Outstanding counter (OUTST_W bits):
  - +1 on incr_req_i.
  - −1 on a merged-port rlast handshake (ERR beats excluded).
  - incr and decr in the same cycle: unchanged.
  - Saturates at 0 and at all-ones.
  - full_counter_o = (cnt==all-ones).
- Upstream must stall AR while err_pending_o=1. If it does not, ERR waits until the counter drains to 0.

## Timing
- Reset values:
  - FSM=ARB, rr_ptr=N_INIT_PORT-1, counter=0, queue empty, beat counter=0.
  - Outputs: rvalid_o=0, rready_o=0, full_counter_o=0, outstanding_trans_o=0, err_pending_o=0, err_gnt_o=1. All payload outputs are 0 while rst=1.
- Pass-through from input to output is zero-latency (combinational). State updates on the clk edge after the handshake.
- ERR is entered one cycle after the counter reaches 0, and at the earliest one cycle after the push.
- err_pending_o is registered and rises the cycle after the push.
- Asserting rst mid-burst or mid-ERR discards the lock, the queue, and the counter immediately.

## Test plan
- Single-beat round-robin: ports 0 and 2 assert rvalid continuously, rready_i=1 → grants alternate 0,2,0,2; rid_o equals the low AXI_ID_IN bits of rid_i.
- Burst lock: port 1 sends a 4-beat burst; port 3 is valid throughout → rready_o[3]=0 until port 1's rlast handshake; port 3 is granted on the next cycle.
- Error after drain:
  - Setup: counter=2, then push err len=3, id=0x5A.
  - ERR is entered only after 2 rlast handshakes.
  - Required response: 4 beats of rdata=DEADBEEF_DEADBEEF, rresp=2'b11, rid_o=0x5A, rlast_o only on beat 4.
  - err_pending_o falls after the pop.
- Queue full: 5 back-to-back pushes with ERR_DEPTH=4 → err_gnt_o=0 on the 5th; a push together with a pop in the same cycle is accepted.
- Counter boundaries:
  - 1023 incr with OUTST_W=10 → full_counter_o=1; a further incr stays at 1023.
  - incr+decr in the same cycle → unchanged.
  - decr at 0 → stays at 0.
- Reset mid-burst: rst asserted during beat 2 of a locked burst → rvalid_o=0 and all rready_o=0 immediately; after release, arbitration restarts from port 0.
